// File: rtl/branch_sequencer.sv
// branch_sequencer: multicycle conditional-branch resolution controller.
//   Accepts a branch from decode, waits for the ALU compare flags, picks the
//   flag selected by funct3, then drives the PC update (target or
//   fall-through) and holds the fetch flush for FLUSH_CYCLES after a taken
//   branch. Flags illegal funct3, misaligned taken targets and flag timeouts,
//   and keeps saturating branch statistics.
// Ports:
//   clk, reset           clock (rising edge), async active-high reset
//   issue_valid/ready    decode handshake (ready only in IDLE)
//   funct3, pc, imm      branch descriptor, sampled on the handshake
//   flags, flags_valid   ALU compare flags {GEU,LTU,GE,LT,NE,EQ}
//   pc_load, pc_next     one-cycle PC write strobe and value
//   taken, done          resolution result and completion pulse
//   flush                fetch/decode flush
//   err_illegal/err_misalign/err_timeout  one-cycle error pulses
//   branch_count, taken_count             saturating statistics
module branch_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 15,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [2:0]       funct3,
  input  logic [31:0]      pc,
  input  logic [31:0]      imm,
  input  logic [5:0]       flags,
  input  logic             flags_valid,
  output logic             pc_load,
  output logic [31:0]      pc_next,
  output logic             taken,
  output logic             done,
  output logic             flush,
  output logic             err_illegal,
  output logic             err_misalign,
  output logic             err_timeout,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_UPDATE, S_FLUSH} state_t;

  state_t           r_state, w_state;
  logic [2:0]       r_funct3, w_funct3;
  logic [31:0]      r_pc, w_pc;
  logic [31:0]      r_imm, w_imm;
  logic [7:0]       r_tcnt, w_tcnt;
  logic [FW-1:0]    r_fcnt, w_fcnt;
  logic             r_pc_load, w_pc_load;
  logic [31:0]      r_pc_next, w_pc_next;
  logic             r_taken, w_taken;
  logic             r_done, w_done;
  logic             r_flush, w_flush;
  logic             r_err_ill, w_err_ill;
  logic             r_err_mis, w_err_mis;
  logic             r_err_to, w_err_to;
  logic [CNT_W-1:0] r_bcnt, w_bcnt;
  logic [CNT_W-1:0] r_tkcnt, w_tkcnt;

  logic             w_legal;
  logic [2:0]       w_idx;
  logic             w_flag;
  logic [31:0]      w_target;
  logic [31:0]      w_fall;

  // Legality is checked on the live funct3 at issue; the flag index uses the
  // latched copy while waiting for flags.
  assign w_legal  = (funct3 != 3'b010) && (funct3 != 3'b011);
  assign w_target = r_pc + r_imm;
  assign w_fall   = r_pc + 32'd4;

  always_comb begin
    w_idx = 3'd0;
    case (r_funct3)
      3'b000:  w_idx = 3'd0;
      3'b001:  w_idx = 3'd1;
      3'b100:  w_idx = 3'd2;
      3'b101:  w_idx = 3'd3;
      3'b110:  w_idx = 3'd4;
      3'b111:  w_idx = 3'd5;
      default: w_idx = 3'd0;
    endcase
  end

  assign w_flag = flags[w_idx];

  always_comb begin
    w_state   = r_state;
    w_funct3  = r_funct3;
    w_pc      = r_pc;
    w_imm     = r_imm;
    w_tcnt    = r_tcnt;
    w_fcnt    = r_fcnt;
    w_pc_load = 1'b0;
    w_pc_next = '0;
    w_taken   = 1'b0;
    w_done    = 1'b0;
    w_flush   = 1'b0;
    w_err_ill = 1'b0;
    w_err_mis = 1'b0;
    w_err_to  = 1'b0;
    w_bcnt    = r_bcnt;
    w_tkcnt   = r_tkcnt;

    case (r_state)
      S_IDLE: begin
        if (issue_valid) begin
          w_funct3 = funct3;
          w_pc     = pc;
          w_imm    = imm;
          if (w_legal) begin
            w_state = S_WAIT;
            w_tcnt  = '0;
          end else begin
            w_err_ill = 1'b1;
          end
        end
      end

      S_WAIT: begin
        // The result is registered on the flag-sampling edge so the PC
        // strobe and counters are visible during the UPDATE cycle.
        if (flags_valid) begin
          w_state = S_UPDATE;
          if (!w_flag) begin
            w_pc_load = 1'b1;
            w_pc_next = w_fall;
            w_done    = 1'b1;
            if (r_bcnt != '1) w_bcnt = r_bcnt + CNT_W'(1);
          end else if (w_target[1:0] != 2'b00) begin
            w_err_mis = 1'b1;
          end else begin
            w_pc_load = 1'b1;
            w_pc_next = w_target;
            w_done    = 1'b1;
            w_taken   = 1'b1;
            if (r_bcnt != '1)  w_bcnt  = r_bcnt + CNT_W'(1);
            if (r_tkcnt != '1) w_tkcnt = r_tkcnt + CNT_W'(1);
          end
        end else if (r_tcnt == 8'(TIMEOUT - 1)) begin
          w_err_to = 1'b1;
          w_state  = S_IDLE;
        end else begin
          w_tcnt = r_tcnt + 8'd1;
        end
      end

      S_UPDATE: begin
        if (r_pc_load && r_taken && (FLUSH_CYCLES > 0)) begin
          w_state = S_FLUSH;
          w_flush = 1'b1;
          w_fcnt  = FW'(1);
        end else begin
          w_state = S_IDLE;
        end
      end

      S_FLUSH: begin
        if (r_fcnt >= FW'(FLUSH_CYCLES)) begin
          w_state = S_IDLE;
        end else begin
          w_flush = 1'b1;
          w_fcnt  = r_fcnt + FW'(1);
        end
      end

      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_funct3  <= '0;
      r_pc      <= '0;
      r_imm     <= '0;
      r_tcnt    <= '0;
      r_fcnt    <= '0;
      r_pc_load <= 1'b0;
      r_pc_next <= '0;
      r_taken   <= 1'b0;
      r_done    <= 1'b0;
      r_flush   <= 1'b0;
      r_err_ill <= 1'b0;
      r_err_mis <= 1'b0;
      r_err_to  <= 1'b0;
      r_bcnt    <= '0;
      r_tkcnt   <= '0;
    end else begin
      r_state   <= w_state;
      r_funct3  <= w_funct3;
      r_pc      <= w_pc;
      r_imm     <= w_imm;
      r_tcnt    <= w_tcnt;
      r_fcnt    <= w_fcnt;
      r_pc_load <= w_pc_load;
      r_pc_next <= w_pc_next;
      r_taken   <= w_taken;
      r_done    <= w_done;
      r_flush   <= w_flush;
      r_err_ill <= w_err_ill;
      r_err_mis <= w_err_mis;
      r_err_to  <= w_err_to;
      r_bcnt    <= w_bcnt;
      r_tkcnt   <= w_tkcnt;
    end
  end

  assign issue_ready  = (r_state == S_IDLE);
  assign pc_load      = r_pc_load;
  assign pc_next      = r_pc_next;
  assign taken        = r_taken;
  assign done         = r_done;
  assign flush        = r_flush;
  assign err_illegal  = r_err_ill;
  assign err_misalign = r_err_mis;
  assign err_timeout  = r_err_to;
  assign branch_count = r_bcnt;
  assign taken_count  = r_tkcnt;

endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: directed bench for branch_sequencer (default params).
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  funct3;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [5:0]  flags;
  logic        flags_valid;
  logic        pc_load;
  logic [31:0] pc_next;
  logic        taken;
  logic        done;
  logic        flush;
  logic        err_illegal;
  logic        err_misalign;
  logic        err_timeout;
  logic [15:0] branch_count;
  logic [15:0] taken_count;

  int n_checks = 0;
  int n_errors = 0;

  branch_sequencer #(.FLUSH_CYCLES(2), .TIMEOUT(15), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .funct3       (funct3),
    .pc           (pc),
    .imm          (imm),
    .flags        (flags),
    .flags_valid  (flags_valid),
    .pc_load      (pc_load),
    .pc_next      (pc_next),
    .taken        (taken),
    .done         (done),
    .flush        (flush),
    .err_illegal  (err_illegal),
    .err_misalign (err_misalign),
    .err_timeout  (err_timeout),
    .branch_count (branch_count),
    .taken_count  (taken_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs set before the call are sampled on this edge; outputs
  // are read 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] p, input logic [31:0] im);
    issue_valid = 1'b1;
    funct3      = f3;
    pc          = p;
    imm         = im;
    step();
    issue_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; issue_valid = 1'b0; funct3 = '0; pc = '0; imm = '0;
    flags = '0; flags_valid = 1'b0;
    #12;
    chk("rst_ready", 32'(issue_ready), 32'd1);
    chk("rst_pc_load", 32'(pc_load), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_bcnt", 32'(branch_count), 32'd0);
    chk("rst_tcnt", 32'(taken_count), 32'd0);
    reset = 1'b0;
    step();

    // BEQ taken, flags the cycle after issue
    issue(3'b000, 32'h100, 32'h20);
    chk("beq_wait_ready", 32'(issue_ready), 32'd0);
    chk("beq_wait_pcload", 32'(pc_load), 32'd0);
    flags = 6'b000001; flags_valid = 1'b1;
    step();
    flags_valid = 1'b0;
    chk("beq_pc_load", 32'(pc_load), 32'd1);
    chk("beq_pc_next", pc_next, 32'h120);
    chk("beq_taken", 32'(taken), 32'd1);
    chk("beq_done", 32'(done), 32'd1);
    chk("beq_flush0", 32'(flush), 32'd0);
    chk("beq_bcnt", 32'(branch_count), 32'd1);
    chk("beq_tcnt", 32'(taken_count), 32'd1);
    step();
    chk("beq_flush1", 32'(flush), 32'd1);
    chk("beq_pcload_off", 32'(pc_load), 32'd0);
    chk("beq_ready_f1", 32'(issue_ready), 32'd0);
    step();
    chk("beq_flush2", 32'(flush), 32'd1);
    chk("beq_ready_f2", 32'(issue_ready), 32'd0);
    step();
    chk("beq_flush_end", 32'(flush), 32'd0);
    chk("beq_ready_back", 32'(issue_ready), 32'd1);

    // BLTU not taken, flags delayed 3 cycles; issue_valid held with junk meanwhile
    issue(3'b110, 32'h200, 32'h40);
    flags = 6'b101010;
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; funct3 = 3'b010; pc = 32'hDEAD;
      step();
      chk("bltu_wait_ill", 32'(err_illegal), 32'd0);
      chk("bltu_wait_pcload", 32'(pc_load), 32'd0);
    end
    issue_valid = 1'b0;
    flags_valid = 1'b1;
    step();
    flags_valid = 1'b0;
    chk("bltu_pc_load", 32'(pc_load), 32'd1);
    chk("bltu_pc_next", pc_next, 32'h204);
    chk("bltu_taken", 32'(taken), 32'd0);
    chk("bltu_done", 32'(done), 32'd1);
    chk("bltu_bcnt", 32'(branch_count), 32'd2);
    chk("bltu_tcnt", 32'(taken_count), 32'd1);
    step();
    chk("bltu_noflush", 32'(flush), 32'd0);
    chk("bltu_ready", 32'(issue_ready), 32'd1);

    // Illegal funct3
    issue(3'b010, 32'h400, 32'h8);
    chk("ill_pulse", 32'(err_illegal), 32'd1);
    chk("ill_ready", 32'(issue_ready), 32'd1);
    chk("ill_pcload", 32'(pc_load), 32'd0);
    step();
    chk("ill_pulse_end", 32'(err_illegal), 32'd0);
    chk("ill_bcnt", 32'(branch_count), 32'd2);

    // BNE taken to a misaligned target
    issue(3'b001, 32'h100, 32'h6);
    flags = 6'b000010; flags_valid = 1'b1;
    step();
    flags_valid = 1'b0;
    chk("mis_pulse", 32'(err_misalign), 32'd1);
    chk("mis_pcload", 32'(pc_load), 32'd0);
    chk("mis_done", 32'(done), 32'd0);
    step();
    chk("mis_pulse_end", 32'(err_misalign), 32'd0);
    chk("mis_noflush", 32'(flush), 32'd0);
    chk("mis_ready", 32'(issue_ready), 32'd1);
    chk("mis_bcnt", 32'(branch_count), 32'd2);
    chk("mis_tcnt", 32'(taken_count), 32'd1);

    // BGE timeout: 15 cycles without flags_valid
    flags = 6'b001000;
    issue(3'b101, 32'h300, 32'h40);
    for (int i = 0; i < 14; i++) step();
    chk("to_not_yet", 32'(err_timeout), 32'd0);
    chk("to_still_wait", 32'(issue_ready), 32'd0);
    step();
    chk("to_pulse", 32'(err_timeout), 32'd1);
    chk("to_pcload", 32'(pc_load), 32'd0);
    chk("to_ready", 32'(issue_ready), 32'd1);
    step();
    chk("to_pulse_end", 32'(err_timeout), 32'd0);

    // BGE with flags arriving on the 15th wait cycle
    issue(3'b101, 32'h300, 32'h40);
    for (int i = 0; i < 14; i++) step();
    flags_valid = 1'b1;
    step();
    flags_valid = 1'b0;
    chk("late_pcload", 32'(pc_load), 32'd1);
    chk("late_pc_next", pc_next, 32'h340);
    chk("late_no_to", 32'(err_timeout), 32'd0);
    chk("late_bcnt", 32'(branch_count), 32'd3);
    chk("late_tcnt", 32'(taken_count), 32'd2);
    step();
    chk("late_flush1", 32'(flush), 32'd1);
    step();
    chk("late_flush2", 32'(flush), 32'd1);

    // Asynchronous reset during the second flush cycle
    #2;
    reset = 1'b1;
    #1;
    chk("arst_flush", 32'(flush), 32'd0);
    chk("arst_pcload", 32'(pc_load), 32'd0);
    chk("arst_bcnt", 32'(branch_count), 32'd0);
    chk("arst_tcnt", 32'(taken_count), 32'd0);
    reset = 1'b0;
    step();
    chk("arst_ready", 32'(issue_ready), 32'd1);
    chk("arst_flush_after", 32'(flush), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
